// File: rtl/texture_refill_engine_if.sv
// rtl/texture_refill_engine_if.sv - cache miss port and memory burst-read port of the refill engine
interface texture_refill_engine_if #(
  parameter int LINE_BYTES    = 64,
  parameter int MEM_DATA_BITS = 32
);
  logic                     miss_req_valid;
  logic [31:0]              miss_req_addr;
  logic                     miss_req_ready;
  logic                     miss_resp_valid;
  logic [LINE_BYTES*8-1:0]  miss_resp_data;
  logic                     mem_req_valid;
  logic [31:0]              mem_req_addr;
  logic [7:0]               mem_req_len;
  logic                     mem_req_ready;
  logic                     mem_rdata_valid;
  logic [MEM_DATA_BITS-1:0] mem_rdata;

  modport slave (
    input  miss_req_valid, miss_req_addr, mem_req_ready, mem_rdata_valid, mem_rdata,
    output miss_req_ready, miss_resp_valid, miss_resp_data,
    output mem_req_valid, mem_req_addr, mem_req_len
  );

  modport master (
    output miss_req_valid, miss_req_addr, mem_req_ready, mem_rdata_valid, mem_rdata,
    input  miss_req_ready, miss_resp_valid, miss_resp_data,
    input  mem_req_valid, mem_req_addr, mem_req_len
  );
endinterface

// File: rtl/texture_refill_engine.sv
// rtl/texture_refill_engine.sv - single-outstanding texture line refill (burst read, beat assembly, refill pulse)
// Optional DATA-phase watchdog enabled by defining TEX_REFILL_TIMEOUT_EN.
module texture_refill_engine #(
  parameter int LINE_BYTES     = 64,
  parameter int MEM_DATA_BITS  = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  texture_refill_engine_if.slave  bus,
  output logic                    busy,
  output logic                    err_timeout
);
  localparam int LINE_BITS   = LINE_BYTES * 8;
  localparam int BEATS       = LINE_BITS / MEM_DATA_BITS;
  localparam int OFFSET_BITS = $clog2(LINE_BYTES);
  localparam int CNT_BITS    = $clog2(BEATS) + 1;
  localparam int IDX_BITS    = $clog2(LINE_BITS);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t               state;
  logic [CNT_BITS-1:0]  cnt;
  logic [LINE_BITS-1:0] line_buf;
  logic [31:0]          addr_q;
  logic                 req_ready_q;
  logic                 req_valid_q;
  logic                 resp_valid_q;
  logic [IDX_BITS-1:0]  beat_base;

  assign beat_base = IDX_BITS'(cnt) * IDX_BITS'(MEM_DATA_BITS);

`ifdef TEX_REFILL_TIMEOUT_EN
  localparam int WD_BITS = $clog2(TIMEOUT_CYCLES + 1);
  // Cycles since the last beat (or DATA entry), that beat's own cycle counting as one.
  logic [WD_BITS-1:0] wd_cnt;
  logic               err_q;
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      line_buf     <= '0;
      addr_q       <= '0;
      req_ready_q  <= 1'b0;
      req_valid_q  <= 1'b0;
      resp_valid_q <= 1'b0;
`ifdef TEX_REFILL_TIMEOUT_EN
      wd_cnt       <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (bus.miss_req_valid && req_ready_q) begin
            addr_q      <= {bus.miss_req_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            cnt         <= '0;
            req_ready_q <= 1'b0;
            req_valid_q <= 1'b1;
            state       <= ADDR;
          end
        end
        ADDR: begin
          if (bus.mem_req_ready) begin
            req_valid_q <= 1'b0;
            state       <= DATA;
`ifdef TEX_REFILL_TIMEOUT_EN
            wd_cnt      <= WD_BITS'(1);
`endif
          end
        end
        DATA: begin
          if (bus.mem_rdata_valid) begin
            line_buf[beat_base +: MEM_DATA_BITS] <= bus.mem_rdata;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_BITS'(BEATS - 1)) begin
              resp_valid_q <= 1'b1;
              state        <= RESP;
            end
`ifdef TEX_REFILL_TIMEOUT_EN
            wd_cnt <= WD_BITS'(1);
          end else if (wd_cnt == WD_BITS'(TIMEOUT_CYCLES - 1)) begin
            // Zero every beat not yet received so the cache gets a defined line.
            line_buf     <= line_buf & ~({LINE_BITS{1'b1}} << beat_base);
            err_q        <= 1'b1;
            resp_valid_q <= 1'b1;
            state        <= RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
`endif
          end
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy                = (state != IDLE);
  assign bus.miss_req_ready  = req_ready_q;
  assign bus.miss_resp_valid = resp_valid_q;
  assign bus.miss_resp_data  = line_buf;
  assign bus.mem_req_valid   = req_valid_q;
  assign bus.mem_req_addr    = addr_q;
  assign bus.mem_req_len     = 8'(BEATS - 1);
endmodule

// File: doc/texture_refill_engine.md
# texture_refill_engine

Line-refill engine sitting directly downstream of the texture cache's miss port. It accepts a single outstanding line-miss request, issues one burst read to the external memory/OSPI controller, and assembles the returned narrow beats into a full cache line. It then presents that line to the cache as a one-cycle refill pulse. One refill is in flight at a time; the cache holds its miss request until the pulse arrives.

## Interface
Parameters:
- LINE_BYTES, 64, cache line size in bytes; power of two, ≥ MEM_DATA_BITS/8.
- MEM_DATA_BITS, 32, memory read-beat width; power of two, divides LINE_BYTES*8.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only when TEX_REFILL_TIMEOUT_EN is defined.

Derived values:
- BEATS = LINE_BYTES*8/MEM_DATA_BITS (16 by default).
- OFFSET_BITS = log2(LINE_BYTES).

Ports:
- clk  in  1  sole clock; rising edge.
- rst  in  1  asynchronous, active-high reset.
- miss_req_valid  in  1  cache requests a line refill.
- miss_req_addr  in  32  miss address; low OFFSET_BITS are ignored.
- miss_req_ready  out  1  engine is idle and can accept a request.
- miss_resp_valid  out  1  one-cycle pulse: the line is complete.
- miss_resp_data  out  LINE_BYTES*8  assembled line.
- mem_req_valid  out  1  burst read request to memory.
- mem_req_addr  out  32  line-aligned burst address.
- mem_req_len  out  8  constant BEATS-1.
- mem_req_ready  in  1  memory accepts the burst.
- mem_rdata_valid  in  1  read beat valid.
- mem_rdata  in  MEM_DATA_BITS  read beat data.
- busy  out  1  engine is in any state other than IDLE.
- err_timeout  out  1  sticky watchdog flag; tied 0 unless TEX_REFILL_TIMEOUT_EN is defined.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - miss_req_ready=1.
  - On miss_req_valid&&miss_req_ready: latch {miss_req_addr[31:OFFSET_BITS], OFFSET_BITS'b0} into mem_req_addr, clear the beat counter, go to ADDR.
  - The line buffer is not cleared on acceptance.
- ADDR:
  - mem_req_valid=1; mem_req_addr is held stable.
  - On mem_req_ready, go to DATA.
  - mem_rdata_valid is ignored in this state.
- DATA:
  - Each mem_rdata_valid writes mem_rdata into buffer bits [cnt*MEM_DATA_BITS +: MEM_DATA_BITS], then increments cnt. Beat 0 is the lowest address.
  - The beat that makes cnt==BEATS moves the FSM to RESP.
  - The counter is log2(BEATS)+1 bits wide and never wraps within a refill.
- RESP:
  - miss_resp_valid=1 for exactly one cycle, then go to IDLE.
  - mem_rdata_valid is ignored (extra beats are dropped).
- miss_resp_data is driven directly from the buffer. It stays stable from RESP until the first beat of the next refill.
- miss_req_valid held high during ADDR/DATA/RESP is not re-accepted. miss_req_ready=0 in those states.
- mem_rdata_valid in IDLE is ignored. This covers stray beats after a reset mid-burst.
- busy = (state != IDLE).

## Timing
- Request accepted at edge T → ADDR during T+1. mem_req_valid is a decoded registered state, not combinational from miss_req_valid.
- With mem_req_ready=1 and one beat per cycle:
  - DATA from T+2.
  - Beats at T+2..T+BEATS+1.
  - miss_resp_valid during T+BEATS+2 (T+18 by default).
  - IDLE, ready for a new request, at T+BEATS+3.
- Gaps in mem_rdata_valid extend DATA cycle-for-cycle.
- Reset (async, any state):
  - State returns to IDLE and the counter clears.
  - miss_req_ready=0 while rst is high, 1 from the first cycle after release.
  - mem_req_valid=0, mem_req_addr=0, miss_resp_valid=0, miss_resp_data=0, busy=0, err_timeout=0.
  - A reset mid-burst abandons the burst; any late beats are then dropped in IDLE.

## Configuration
- Macro: TEX_REFILL_TIMEOUT_EN.
- Defined:
  - A watchdog counts consecutive cycles in DATA with no mem_rdata_valid; it resets on every beat.
  - On reaching TIMEOUT_CYCLES: unreceived beats are zero-filled, err_timeout is set (sticky until rst), and the FSM goes to RESP. The cache therefore never stalls forever.
  - ADDR is not watched.
- Not defined:
  - No watchdog logic.
  - DATA waits indefinitely.
  - err_timeout is constant 0.

## Test plan
- Basic refill: miss_req_addr=0x0000_1234, mem_req_ready=1, beats 0x1000_0000+i → mem_req_addr=0x0000_1200, mem_req_len=15, miss_resp_valid exactly at T+18, miss_resp_data word i = 0x1000_0000+i.
- Back-pressure and gaps: mem_req_ready low for 5 cycles, one idle cycle between each beat → still exactly one miss_resp_valid, data correct, busy high from T+1 through RESP.
- Held request: miss_req_valid stays high through the entire refill → exactly one memory burst issued, miss_req_ready=0 until IDLE.
- Stray beats: mem_rdata_valid pulsed in IDLE, in ADDR, and as a 17th beat in RESP → buffer unchanged by these, no extra miss_resp_valid.
- Reset mid-burst: assert rst after beat 7, release, issue a new request to 0x0000_2000 → no miss_resp_valid for the aborted burst, all outputs at reset values, new refill completes correctly.
- Timeout (TEX_REFILL_TIMEOUT_EN, TIMEOUT_CYCLES=8): stop after 4 beats → miss_resp_valid 8 cycles after the last beat, words 4..15 = 0, err_timeout=1 and still 1 after the next normal refill.
